logic_frame_packer: RTL and testbench

LOGIC_FRAME_PACKER -- requirements
Module: logic_frame_packer

---
 rtl/logic_frame_packer_pkg.sv | 22 ++
 rtl/logic_frame_packer_sync_fifo.sv | 54 +++++
 rtl/logic_frame_packer.sv | 141 ++++++++++++++
 tb/tb_logic_frame_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_frame_packer_pkg.sv
// Shared types and defaults for the logic-analyzer frame packer.
// Holds the header byte defaults, the FSM state encoding and the frame-length helper.
package logic_frame_packer_pkg;

  localparam logic [7:0] HEAD0_DEFAULT = 8'h55;
  localparam logic [7:0] HEAD1_DEFAULT = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD0,
    ST_HEAD1,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } pack_state_t;

  // Frame length is the buffered byte count capped at the per-frame maximum.
  function automatic logic [7:0] frame_len(input logic [15:0] count, input logic [15:0] max_len);
    return (count >= max_len) ? max_len[7:0] : count[7:0];
  endfunction

endpackage

// File: rtl/logic_frame_packer_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on rd_data.
// Writes when full and reads when empty are ignored, so pointers never wrap onto live data.
module sync_fifo #(
  parameter int P_AW = 9,
  parameter int P_DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [P_DW-1:0] wr_data,
  input  logic            rd_en,
  output logic [P_DW-1:0] rd_data,
  output logic            full,
  output logic            empty,
  output logic [P_AW:0]   count
);

  localparam int DEPTH = 1 << P_AW;
  localparam logic [P_AW:0] FULL_CNT = {1'b1, {P_AW{1'b0}}};

  logic [P_DW-1:0] mem [DEPTH];
  logic [P_AW-1:0] wr_ptr;
  logic [P_AW-1:0] rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // A simultaneous write and read leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_frame_packer.sv
// Buffers captured sample bytes and sends them to the UART as framed packets:
// HEAD0, HEAD1, LEN, payload, CHK (mod-256 sum of LEN and payload).
module logic_frame_packer
  import logic_frame_packer_pkg::*;
#(
  parameter int         P_FIFO_AW = 9,
  parameter int         P_MAX_LEN = 255,
  parameter logic [7:0] P_HEAD0   = HEAD0_DEFAULT,
  parameter logic [7:0] P_HEAD1   = HEAD1_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_sam_data,
  input  logic       i_sam_data_vld,
  input  logic       i_sam_data_last,
  output logic       o_sam_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_drop,
  output logic       o_frame_done
);

  pack_state_t        state;
  pack_state_t        state_next;
  logic               last_pending;
  logic               drop_flag;
  logic               frame_done_r;
  logic [7:0]         len_r;
  logic [7:0]         remain;
  logic [7:0]         chk_r;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_wr;
  logic               fifo_rd;
  logic [P_FIFO_AW:0] fifo_count;
  logic [7:0]         fifo_data;
  logic               sam_ready;
  logic               frame_start;
  logic               capture_done;
  logic               tx_valid;
  logic               tx_fire;
  logic [7:0]         tx_data;
  logic [7:0]         len_next;

  // Once the last sample of a capture is in, input is held off until that capture drains,
  // which keeps bytes of two captures out of one frame.
  assign sam_ready    = ~fifo_full & ~last_pending;
  assign fifo_wr      = i_sam_data_vld & sam_ready & ~i_rst;
  assign tx_fire      = tx_valid & i_tx_ready;
  assign fifo_rd      = tx_fire & (state == ST_DATA);
  assign len_next     = frame_len(16'(fifo_count), 16'(P_MAX_LEN));
  assign frame_start  = (16'(fifo_count) >= 16'(P_MAX_LEN)) | (last_pending & ~fifo_empty);
  assign capture_done = tx_fire & (state == ST_CHK) & last_pending & fifo_empty;

  assign o_sam_ready  = sam_ready & ~i_rst;
  assign o_tx_valid   = tx_valid & ~i_rst;
  assign o_tx_data    = i_rst ? 8'h00 : tx_data;
  assign o_drop       = drop_flag & ~i_rst;
  assign o_frame_done = frame_done_r & ~i_rst;

  sync_fifo #(
    .P_AW(P_FIFO_AW),
    .P_DW(8)
  ) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (fifo_wr),
    .wr_data(i_sam_data),
    .rd_en  (fifo_rd),
    .rd_data(fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (frame_start) state_next = ST_HEAD0;
      ST_HEAD0: if (i_tx_ready) state_next = ST_HEAD1;
      ST_HEAD1: if (i_tx_ready) state_next = ST_LEN;
      ST_LEN:   if (i_tx_ready) state_next = ST_DATA;
      ST_DATA:  if (i_tx_ready && remain == 8'd1) state_next = ST_CHK;
      ST_CHK:   if (i_tx_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    case (state)
      ST_HEAD0: tx_data = P_HEAD0;
      ST_HEAD1: tx_data = P_HEAD1;
      ST_LEN:   tx_data = len_r;
      ST_DATA:  tx_data = fifo_data;
      ST_CHK:   tx_data = chk_r;
      default:  tx_valid = 1'b0;
    endcase
  end

  // The checksum is seeded with LEN at frame start and accumulates each payload byte as it leaves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_pending <= 1'b0;
      drop_flag    <= 1'b0;
      frame_done_r <= 1'b0;
      len_r        <= 8'h00;
      remain       <= 8'h00;
      chk_r        <= 8'h00;
    end else begin
      frame_done_r <= capture_done;
      if (i_sam_data_vld && !sam_ready) drop_flag <= 1'b1;
      if (fifo_wr && i_sam_data_last) last_pending <= 1'b1;
      else if (capture_done)          last_pending <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            len_r  <= len_next;
            remain <= len_next;
            chk_r  <= len_next;
          end
        end
        ST_DATA: begin
          if (tx_fire) begin
            remain <= remain - 8'd1;
            chk_r  <= chk_r + fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_frame_packer.sv
// Scoreboard bench for logic_frame_packer: expected frame bytes are queued as samples
// are driven and popped as the DUT hands each byte to the UART.
module tb_logic_frame_packer;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sam_data = 8'h00;
  logic       sam_vld = 1'b0;
  logic       sam_last = 1'b0;
  logic       tx_ready = 1'b0;
  logic       o_sam_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_drop;
  logic       o_frame_done;

  int      checks = 0;
  int      errors = 0;
  int      done_cnt = 0;
  int      ready_mode = 0;
  bit      mon_en = 1'b0;
  byte_q_t exp_q;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  logic_frame_packer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sam_data     (sam_data),
    .i_sam_data_vld (sam_vld),
    .i_sam_data_last(sam_last),
    .o_sam_ready    (o_sam_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (tx_ready),
    .o_drop         (o_drop),
    .o_frame_done   (o_frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // UART backpressure: 0 = always ready, 1 = never ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'b0;
      default: tx_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: byte scoreboard plus hold-stability of a stalled byte.
  always @(negedge clk) begin
    if (o_frame_done) done_cnt++;
    if (mon_en && !rst) begin
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", {31'd0, o_tx_valid}, 32'd1);
        checkOutput("hold_data", {24'd0, o_tx_data}, {24'd0, prev_data});
      end
      if (o_tx_valid && tx_ready) begin
        if (exp_q.size() == 0) checkOutput("extra_byte", {24'd0, o_tx_data}, 32'h100);
        else                   checkOutput("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = o_tx_valid && !rst;
    prev_ready = tx_ready;
    prev_data  = o_tx_data;
  end

  // Reference framing: each capture splits into 255-byte frames plus a remainder frame.
  task automatic pushCapture(input byte_q_t s);
    int idx = 0;
    while (idx < s.size()) begin
      int n;
      logic [7:0] c;
      n = s.size() - idx;
      if (n > 255) n = 255;
      c = n[7:0];
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(n[7:0]);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(s[idx + i]);
        c = c + s[idx + i];
      end
      exp_q.push_back(c);
      idx += n;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l, output logic acc);
    sam_data = d;
    sam_last = l;
    sam_vld  = 1'b1;
    @(negedge clk);
    acc = o_sam_ready;
    @(posedge clk);
    #1;
    sam_vld  = 1'b0;
    sam_last = 1'b0;
  endtask

  task automatic sendCapture(input byte_q_t s);
    logic acc;
    foreach (s[i]) applyStimulus(s[i], (i == s.size() - 1), acc);
  endtask

  task automatic waitDrain(input int budget, input int exp_done, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, exp_q.size(), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput({tag, "_done"}, done_cnt, exp_done);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic    acc;
    byte_q_t s;
    int      accepted;
    bit      found;

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    checkOutput("rst_drop", {31'd0, o_drop}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
    checkOutput("rst_sam_ready", {31'd0, o_sam_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, o_sam_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] basic three-sample capture");
    mon_en = 1'b1;
    ready_mode = 0;
    s = '{8'h01, 8'h02, 8'h03};
    pushCapture(s);
    sendCapture(s);
    waitDrain(200, 1, "basic");

    $display("[TB] random backpressure");
    ready_mode = 2;
    pushCapture(s);
    sendCapture(s);
    waitDrain(400, 2, "random");

    $display("[TB] 300-sample capture split across two frames");
    ready_mode = 0;
    s.delete();
    for (int i = 0; i < 300; i++) s.push_back(i[7:0]);
    pushCapture(s);
    sendCapture(s);
    waitDrain(3000, 3, "long");

    $display("[TB] samples after last are dropped");
    ready_mode = 1;
    s = '{8'h01, 8'h02, 8'h03};
    pushCapture(s);
    sendCapture(s);
    checkOutput("drop_before_late", {31'd0, o_drop}, 32'd0);
    applyStimulus(8'hEE, 1'b0, acc);
    checkOutput("late_accept", {31'd0, acc}, 32'd0);
    applyStimulus(8'hEF, 1'b1, acc);
    @(negedge clk);
    checkOutput("drop_after_late", {31'd0, o_drop}, 32'd1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    waitDrain(200, 4, "late");

    $display("[TB] fill FIFO with UART stalled");
    doReset(2);
    ready_mode = 1;
    accepted = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(i[7:0], 1'b0, acc);
      if (acc) accepted++;
    end
    @(negedge clk);
    checkOutput("fill_accepted", accepted, 32'd512);
    checkOutput("fill_sam_ready", {31'd0, o_sam_ready}, 32'd0);
    checkOutput("fill_drop", {31'd0, o_drop}, 32'd1);
    checkOutput("fill_tx_valid", {31'd0, o_tx_valid}, 32'd1);
    checkOutput("fill_tx_data", {24'd0, o_tx_data}, 32'h55);
    checkOutput("fill_done", done_cnt, 32'd4);
    @(posedge clk);
    #1;
    ready_mode = 0;
    doReset(2);

    $display("[TB] reset during payload");
    mon_en = 1'b0;
    s.delete();
    for (int i = 0; i < 10; i++) s.push_back(8'hA0 + i[7:0]);
    sendCapture(s);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (o_tx_valid && o_tx_data == 8'hA2) found = 1'b1;
    end
    checkOutput("reach_payload", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("midrst_tx_data", {24'd0, o_tx_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("postrst_sam_ready", {31'd0, o_sam_ready}, 32'd1);
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    s = '{8'h10, 8'h20, 8'h30};
    pushCapture(s);
    sendCapture(s);
    waitDrain(200, 5, "post_rst");

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
